effect_select_stream: RTL

//  Parametrised, streaming successor to the single-cycle effect selector. Chooses one of
//  NUM_EFFECTS pixel streams by a software select value. The select is applied only at

---
 rtl/effect_select_stream_pkg.sv | 18 +
 rtl/pixel_skid_buffer.sv | 66 ++++++
 rtl/effect_select_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/effect_select_stream_pkg.sv
// Shared constants and FSM encoding for the effect-select stream stage.
package effect_select_stream_pkg;

  localparam int unsigned PIXEL_W_DEF     = 24;
  localparam int unsigned NUM_EFFECTS_DEF = 4;
  localparam int unsigned SEL_W_DEF       = 8;
  localparam int unsigned CNT_W_DEF       = 16;

  // Lane indices of the fixed effect kernels
  localparam int unsigned EFFECT_GRAYSCALE = 0;
  localparam int unsigned EFFECT_THRESHOLD = 1;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Generic 2-entry valid/ready register slice; ready_o is registered and
// depends only on skid occupancy, so out_ready never reaches ready_o combinationally.
module pixel_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         ready_q, ready_d;
  logic         push;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    push     = valid_i & ready_q;
    if (!main_v_q || ready_i) begin
      // Output register advances: refill from skid first to keep order
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = push;
        if (push) main_d = data_i;
      end
    end else if (push) begin
      skid_d   = data_i;
      skid_v_d = 1'b1;
    end
    ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = main_q;
  assign valid_o = main_v_q;

endmodule

// File: rtl/effect_select_stream.sv
// Frame-aligned effect lane selector: select latched on SOF, lane mux,
// drop/frame counters, and a registered skid stage toward the video output.
module effect_select_stream
  import effect_select_stream_pkg::*;
#(
  parameter int unsigned PIXEL_W     = PIXEL_W_DEF,
  parameter int unsigned NUM_EFFECTS = NUM_EFFECTS_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [SEL_W-1:0]               sel_req,
  input  logic [NUM_EFFECTS*PIXEL_W-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic                           in_eol,
  output logic                           in_ready,
  output logic [PIXEL_W-1:0]             out_data,
  output logic                           out_valid,
  output logic                           out_sof,
  output logic                           out_eol,
  input  logic                           out_ready,
  output logic [SEL_W-1:0]               active_sel,
  output logic                           sel_err,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic [CNT_W-1:0]               frame_cnt
);

  localparam int unsigned LANE_W = (NUM_EFFECTS > 1) ? $clog2(NUM_EFFECTS) : 1;
  localparam int unsigned PAY_W  = PIXEL_W + 2;
  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NUM_EFFECTS);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   active_sel_q, active_sel_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               sel_err_q, sel_err_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               skid_ready;
  logic               accept;
  logic               sof_beat;
  logic               push;
  logic               sel_in_range;
  logic [LANE_W-1:0]  req_lane;
  logic [LANE_W-1:0]  beat_lane;
  logic [PIXEL_W-1:0] beat_pix;
  logic [PAY_W-1:0]   push_pay;
  logic [PAY_W-1:0]   out_pay;

  // Out-of-range selects fall back to the grayscale lane
  always_comb begin
    sel_in_range = (sel_req < SEL_LIMIT);
    req_lane     = sel_in_range ? LANE_W'(sel_req) : LANE_W'(EFFECT_GRAYSCALE);
    accept       = in_valid & skid_ready;
    sof_beat     = accept & in_sof;
    beat_lane    = sof_beat ? req_lane : lane_q;
    beat_pix     = in_data[beat_lane*PIXEL_W +: PIXEL_W];
    push_pay     = {in_sof, in_eol, beat_pix};
  end

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    lane_d       = lane_q;
    sel_err_d    = sel_err_q;
    drop_cnt_d   = drop_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    push         = 1'b0;
    case (state_q)
      ST_WAIT_SOF: begin
        if (accept) begin
          if (in_sof) begin
            push    = 1'b1;
            state_d = ST_IN_FRAME;
          end else if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_IN_FRAME: push = accept;
      default:     state_d = ST_WAIT_SOF;
    endcase
    if (sof_beat) begin
      active_sel_d = sel_req;
      lane_d       = req_lane;
      frame_cnt_d  = frame_cnt_q + CNT_W'(1);
      if (!sel_in_range) sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WAIT_SOF;
      active_sel_q <= '0;
      lane_q       <= '0;
      sel_err_q    <= 1'b0;
      drop_cnt_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      lane_q       <= lane_d;
      sel_err_q    <= sel_err_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  pixel_skid_buffer #(
    .W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .data_i  (push_pay),
    .valid_i (push),
    .ready_o (skid_ready),
    .data_o  (out_pay),
    .valid_o (out_valid),
    .ready_i (out_ready)
  );

  assign in_ready   = skid_ready;
  assign out_sof    = out_pay[PAY_W-1];
  assign out_eol    = out_pay[PAY_W-2];
  assign out_data   = out_pay[PIXEL_W-1:0];
  assign active_sel = active_sel_q;
  assign sel_err    = sel_err_q;
  assign drop_cnt   = drop_cnt_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
